// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared definitions for the multicycle MIPS controller: state encodings,
//   opcode constants, ALU/PC/operand select codes, the packed control-output
//   bundle and the DECODE dispatch helper.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRC_B_REG   = 2'b00;
  localparam logic [1:0] SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] SRC_B_IMM   = 2'b10;
  localparam logic [1:0] SRC_B_BROFF = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic       bne;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       exc;
  } ctrl_t;

  // Where DECODE dispatches for a given opcode. Unknown opcodes either trap
  // or are retired as a no-op straight back to FETCH.
  function automatic state_t decode_target(input logic [5:0] op, input bit trap_en);
    state_t tgt;
    case (op)
      OP_LW, OP_SW:    tgt = S_MEMADR;
      OP_RTYPE:        tgt = S_EXEC;
      OP_BEQ, OP_BNE:  tgt = S_BRANCH;
      OP_J:            tgt = S_JUMP;
      OP_ADDI:         tgt = S_ADDIEX;
      default:         tgt = trap_en ? S_TRAP : S_FETCH;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode
//   Combinational state -> control-output decode for the multicycle MIPS
//   controller.
// Ports:
//   state       in   current FSM state
//   op_latched  in   opcode captured in DECODE (selects bne in BRANCH)
//   mem_ready   in   memory handshake; qualifies the FETCH IR/PC strobes
//   enable      in   0 forces every output to 0 (used while reset is held)
//   ctrl        out  packed control bundle
module mips_ctrl_decode
  import mips_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  op_latched,
  input  logic        mem_ready,
  input  logic        enable,
  output ctrl_t       ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.pc_source = PC_SRC_ALU;
        // IR load and PC+4 only commit in the cycle the fetch completes.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRC_B_BROFF;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
        ctrl.bne           = (op_latched == OP_BNE);
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
      end
      S_TRAP: begin
        ctrl.exc = 1'b1;
      end
      default: ctrl = '0;
    endcase
    // The reset state register parks in FETCH, whose decode would drive
    // mem_read; gating here keeps every output low for as long as reset is
    // held, and drops them asynchronously the moment it is asserted.
    if (!enable) ctrl = '0;
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Moore control FSM for a multicycle MIPS datapath (lw, sw, R-type, addi,
//   beq, bne, j). Holds the state register, the opcode latch and next-state
//   logic; output decode lives in mips_ctrl_decode.
// Ports:
//   clk                 in   clock, rising edge
//   res                 in   asynchronous active-low reset
//   opcode[5:0]         in   IR[31:26], sampled in DECODE only
//   mem_ready           in   1 = current memory access completes this cycle
//   pc_write .. bne     out  datapath control strobes
//   alu_src_b/alu_op/pc_source [1:0] out  datapath mux selects
//   state[3:0]          out  current state (debug)
//   exc                 out  trap flag
//
// state  | meaning
// FETCH  | read instruction, PC+4; waits for mem_ready
// DECODE | register read, branch target; dispatch on opcode
// MEMADR | lw/sw effective address
// MEMRD  | data read; waits for mem_ready
// MEMWB  | load writeback
// MEMWR  | data write; waits for mem_ready
// EXEC   | R-type ALU operation
// ALUWB  | R-type writeback
// BRANCH | beq/bne compare and conditional PC write
// JUMP   | unconditional PC write
// ADDIEX | addi ALU operation
// ADDIWB | addi writeback
// TRAP   | unknown opcode; sticky until reset
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter bit TRAP_EN = 1'b1
) (
  input  logic       clk,
  input  logic       res,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic       bne,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       exc
);

  state_t     state_q;
  state_t     state_next;
  logic [5:0] op_q;
  ctrl_t      ctrl;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= S_FETCH;
      op_q    <= 6'd0;
    end else begin
      state_q <= state_next;
      if (state_q == S_DECODE) op_q <= opcode;
    end
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: state_next = decode_target(opcode, TRAP_EN);
      // Only lw and sw reach MEMADR, so the latched opcode picks the path.
      S_MEMADR: state_next = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  if (mem_ready) state_next = S_FETCH;
      S_EXEC:   state_next = S_ALUWB;
      S_ALUWB:  state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_JUMP:   state_next = S_FETCH;
      S_ADDIEX: state_next = S_ADDIWB;
      S_ADDIWB: state_next = S_FETCH;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_FETCH;
    endcase
  end

  mips_ctrl_decode u_decode (
    .state      (state_q),
    .op_latched (op_q),
    .mem_ready  (mem_ready),
    .enable     (res),
    .ctrl       (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign bne           = ctrl.bne;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign exc           = ctrl.exc;
  assign state         = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
//   Scoreboard bench: each instruction pushes its expected per-cycle state
//   sequence (with the inputs to drive in that cycle) onto a queue; the drain
//   loop drives, samples at the falling edge and compares. A second instance
//   with TRAP_EN=0 runs in lockstep.
module tb_mips_multicycle_ctrl;

  localparam logic [3:0] ST_FETCH  = 4'd0,  ST_DECODE = 4'd1,  ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD  = 4'd3,  ST_MEMWB  = 4'd4,  ST_MEMWR  = 4'd5;
  localparam logic [3:0] ST_EXEC   = 4'd6,  ST_ALUWB  = 4'd7,  ST_BRANCH = 4'd8;
  localparam logic [3:0] ST_JUMP   = 4'd9,  ST_ADDIEX = 4'd10, ST_ADDIWB = 4'd11;
  localparam logic [3:0] ST_TRAP   = 4'd12;

  localparam logic [5:0] C_LW = 6'b100011, C_SW = 6'b101011, C_RT = 6'b000000;
  localparam logic [5:0] C_BEQ = 6'b000100, C_BNE = 6'b000101, C_J = 6'b000010;
  localparam logic [5:0] C_ADDI = 6'b001000, C_BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       res;
  logic [5:0] opcode;
  logic       mem_ready;

  logic       pc_write0, pc_write_cond0, iord0, mem_read0, mem_write0, ir_write0;
  logic       mem_to_reg0, reg_dst0, reg_write0, alu_src_a0, bne0, exc0;
  logic [1:0] alu_src_b0, alu_op0, pc_source0;
  logic [3:0] state0;

  logic       pc_write1, pc_write_cond1, iord1, mem_read1, mem_write1, ir_write1;
  logic       mem_to_reg1, reg_dst1, reg_write1, alu_src_a1, bne1, exc1;
  logic [1:0] alu_src_b1, alu_op1, pc_source1;
  logic [3:0] state1;

  logic [17:0] obs0, obs1;
  assign obs0 = {pc_write0, pc_write_cond0, iord0, mem_read0, mem_write0, ir_write0,
                 mem_to_reg0, reg_dst0, reg_write0, alu_src_a0, bne0,
                 alu_src_b0, alu_op0, pc_source0, exc0};
  assign obs1 = {pc_write1, pc_write_cond1, iord1, mem_read1, mem_write1, ir_write1,
                 mem_to_reg1, reg_dst1, reg_write1, alu_src_a1, bne1,
                 alu_src_b1, alu_op1, pc_source1, exc1};

  mips_multicycle_ctrl #(.TRAP_EN(1'b1)) dut (
    .clk(clk), .res(res), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write0), .pc_write_cond(pc_write_cond0), .iord(iord0),
    .mem_read(mem_read0), .mem_write(mem_write0), .ir_write(ir_write0),
    .mem_to_reg(mem_to_reg0), .reg_dst(reg_dst0), .reg_write(reg_write0),
    .alu_src_a(alu_src_a0), .bne(bne0), .alu_src_b(alu_src_b0),
    .alu_op(alu_op0), .pc_source(pc_source0), .state(state0), .exc(exc0)
  );

  mips_multicycle_ctrl #(.TRAP_EN(1'b0)) dut_notrap (
    .clk(clk), .res(res), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write1), .pc_write_cond(pc_write_cond1), .iord(iord1),
    .mem_read(mem_read1), .mem_write(mem_write1), .ir_write(ir_write1),
    .mem_to_reg(mem_to_reg1), .reg_dst(reg_dst1), .reg_write(reg_write1),
    .alu_src_a(alu_src_a1), .bne(bne1), .alu_src_b(alu_src_b1),
    .alu_op(alu_op1), .pc_source(pc_source1), .state(state1), .exc(exc1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Expected outputs per state, straight from the state/output table.
  function automatic logic [17:0] exp_out(input logic [3:0] st, input logic mr, input logic bf);
    logic pcw, pcwc, io, mrd, mwr, irw, m2r, rdst, rw, asa, bn, ex;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, io, mrd, mwr, irw, m2r, rdst, rw, asa, bn, ex} = '0;
    {asb, aop, pcs} = '0;
    case (st)
      ST_FETCH:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      ST_DECODE: asb = 2'b11;
      ST_MEMADR: begin asa = 1; asb = 2'b10; end
      ST_MEMRD:  begin mrd = 1; io = 1; end
      ST_MEMWB:  begin rw = 1; m2r = 1; end
      ST_MEMWR:  begin mwr = 1; io = 1; end
      ST_EXEC:   begin asa = 1; aop = 2'b10; end
      ST_ALUWB:  begin rw = 1; rdst = 1; end
      ST_BRANCH: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; bn = bf; end
      ST_JUMP:   begin pcw = 1; pcs = 2'b10; end
      ST_ADDIEX: begin asa = 1; asb = 2'b10; end
      ST_ADDIWB: rw = 1;
      ST_TRAP:   ex = 1;
      default:   ex = 0;
    endcase
    return {pcw, pcwc, io, mrd, mwr, irw, m2r, rdst, rw, asa, bn, asb, aop, pcs, ex};
  endfunction

  typedef struct {
    logic       mr;
    logic [5:0] op;
    logic [3:0] st;
    logic       bf;
    logic       chk1;
    logic [3:0] st1;
  } ent_t;

  ent_t sb[$];

  task automatic push(input logic mr, input logic [5:0] op, input logic [3:0] st,
                      input logic bf, input logic chk1, input logic [3:0] st1);
    ent_t e;
    e.mr = mr; e.op = op; e.st = st; e.bf = bf; e.chk1 = chk1; e.st1 = st1;
    sb.push_back(e);
  endtask

  // Both instances agree on every legal opcode.
  task automatic push2(input logic mr, input logic [5:0] op, input logic [3:0] st, input logic bf);
    push(mr, op, st, bf, 1'b1, st);
  endtask

  function automatic logic [5:0] junk_op();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic instr(input logic [5:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) push2(1'b0, junk_op(), ST_FETCH, 1'b0);
    push2(1'b1, junk_op(), ST_FETCH, 1'b0);
    push2(rbit(), op, ST_DECODE, 1'b0);
    case (op)
      C_LW: begin
        push2(rbit(), junk_op(), ST_MEMADR, 1'b0);
        for (int i = 0; i < mw; i++) push2(1'b0, junk_op(), ST_MEMRD, 1'b0);
        push2(1'b1, junk_op(), ST_MEMRD, 1'b0);
        push2(rbit(), junk_op(), ST_MEMWB, 1'b0);
      end
      C_SW: begin
        push2(rbit(), junk_op(), ST_MEMADR, 1'b0);
        for (int i = 0; i < mw; i++) push2(1'b0, junk_op(), ST_MEMWR, 1'b0);
        push2(1'b1, junk_op(), ST_MEMWR, 1'b0);
      end
      C_RT: begin
        push2(rbit(), junk_op(), ST_EXEC, 1'b0);
        push2(rbit(), junk_op(), ST_ALUWB, 1'b0);
      end
      C_ADDI: begin
        push2(rbit(), junk_op(), ST_ADDIEX, 1'b0);
        push2(rbit(), junk_op(), ST_ADDIWB, 1'b0);
      end
      C_BEQ: push2(rbit(), junk_op(), ST_BRANCH, 1'b0);
      C_BNE: push2(rbit(), junk_op(), ST_BRANCH, 1'b1);
      C_J:   push2(rbit(), junk_op(), ST_JUMP, 1'b0);
      default: ;
    endcase
  endtask

  // Entered just after a rising edge; leaves just after a rising edge.
  task automatic drain();
    ent_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.mr;
      opcode    = e.op;
      @(negedge clk);
      check("state", 32'(state0), 32'(e.st));
      check("outs", 32'(obs0), 32'(exp_out(e.st, e.mr, e.bf)));
      if (e.chk1) begin
        check("notrap_state", 32'(state1), 32'(e.st1));
        check("notrap_outs", 32'(obs1), 32'(exp_out(e.st1, e.mr, e.bf)));
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    res = 1'b0;
    mem_ready = 1'b1;
    opcode = 6'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(state0), 32'(ST_FETCH));
    check("rst_outs", 32'(obs0), 32'd0);
    check("rst_outs_notrap", 32'(obs1), 32'd0);
    @(posedge clk);
    #1;
    res = 1'b1;

    instr(C_LW, 0, 0);
    instr(C_SW, 0, 3);
    instr(C_RT, 0, 0);
    instr(C_ADDI, 1, 0);
    instr(C_BEQ, 0, 0);
    instr(C_BNE, 2, 0);
    instr(C_J, 0, 0);
    instr(C_LW, 0, 2);
    drain();

    // lw stalled in MEMRD, then reset dropped between clock edges.
    push2(1'b1, junk_op(), ST_FETCH, 1'b0);
    push2(1'b1, C_LW, ST_DECODE, 1'b0);
    push2(1'b1, junk_op(), ST_MEMADR, 1'b0);
    push2(1'b0, junk_op(), ST_MEMRD, 1'b0);
    push2(1'b0, junk_op(), ST_MEMRD, 1'b0);
    drain();
    mem_ready = 1'b0;
    #1;
    check("stall_state", 32'(state0), 32'(ST_MEMRD));
    res = 1'b0;
    #1;
    check("async_rst_state", 32'(state0), 32'(ST_FETCH));
    check("async_rst_outs", 32'(obs0), 32'd0);
    check("async_rst_outs_notrap", 32'(obs1), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    res = 1'b1;

    // Unknown opcode: trapping instance sticks in TRAP, the other retires it.
    push2(1'b1, junk_op(), ST_FETCH, 1'b0);
    push2(1'b1, C_BAD, ST_DECODE, 1'b0);
    push(1'b0, junk_op(), ST_TRAP, 1'b0, 1'b1, ST_FETCH);
    for (int i = 0; i < 19; i++) push(rbit(), junk_op(), ST_TRAP, 1'b0, 1'b0, ST_FETCH);
    drain();
    mem_ready = 1'b1;
    res = 1'b0;
    #1;
    check("trap_rst_state", 32'(state0), 32'(ST_FETCH));
    check("trap_rst_outs", 32'(obs0), 32'd0);
    @(posedge clk);
    #1;
    res = 1'b1;
    @(negedge clk);
    check("post_rst_state", 32'(state0), 32'(ST_FETCH));
    check("post_rst_outs", 32'(obs0), 32'(exp_out(ST_FETCH, 1'b1, 1'b0)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 Parameter TRAP_EN, default 1: 1 = an unknown opcode enters TRAP; 0 = an unknown opcode is treated as NOP and returns to FETCH.
REQ-002 clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 res  in  1  asynchronous, active-low reset.
REQ-004 opcode  in  6  instruction register bits [31:26]; sampled only in DECODE.
REQ-005 mem_ready  in  1  memory handshake; 1 = the current access completes this cycle.
REQ-006 pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write  out  1 each  PC, memory and IR control strobes.
REQ-007 mem_to_reg, reg_dst, reg_write, alu_src_a, bne  out  1 each  register-file and ALU control.
REQ-008 alu_src_b  out  2; alu_op  out  2; pc_source  out  2  datapath multiplexer selects.
REQ-009 state  out  4  current state encoding (debug); exc  out  1  trap flag.

Function
REQ-010 Moore FSM; outputs decode from the state register only; mem_ready may gate strobes only where stated.
REQ-011 State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, TRAP=12. Codes 13-15 go to FETCH on the next edge.
REQ-012 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write=1 and pc_write=1 only in a cycle with mem_ready=1. Hold FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-013 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 (R-type) -> EXEC
- 000100 (beq) or 000101 (bne) -> BRANCH
- 000010 (j) -> JUMP
- 001000 (addi) -> ADDIEX
- any other opcode -> TRAP if TRAP_EN=1, else FETCH
REQ-014 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEMRD for lw, MEMWR for sw; the opcode is held in an internal register captured in DECODE.
REQ-015 MEMRD: mem_read=1, iord=1. Hold while mem_ready=0; go to MEMWB on mem_ready=1.
REQ-016 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; then FETCH.
REQ-017 MEMWR: mem_write=1, iord=1. Hold while mem_ready=0; go to FETCH on mem_ready=1.
REQ-018 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; then ALUWB.
REQ-019 ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; then FETCH.
REQ-020 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; bne=1 only if the latched opcode is 000101; then FETCH.
REQ-021 JUMP: pc_write=1, pc_source=10; then FETCH.
REQ-022 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; then ADDIWB.
REQ-023 ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; then FETCH.
REQ-024 TRAP: exc=1 and all strobes 0; remains in TRAP until reset.
REQ-025 Any output not listed for a state is 0.
REQ-026 CPI per instruction type with mem_ready always 1: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3. Each memory wait cycle adds 1.

Reset
REQ-027 While res=0: state=FETCH, latched opcode=0, and all outputs 0, including mem_read and exc.
REQ-028 Reset asserted mid-instruction (including during a stalled MEMRD or MEMWR) aborts immediately; no write strobe is asserted after res falls.
REQ-029 In the first cycle after res rises, the block is in FETCH with mem_read=1.

Structure
REQ-030 A shared package mips_pkg holds the opcode constants, state encodings, and the alu_op and pc_source codes.
REQ-031 One sub-module, mips_ctrl_decode, is natural: combinational state -> output decode. The FSM register and next-state logic stay in the top.

Verification
REQ-032 lw (100011), mem_ready=1 always -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; 5 cycles.
REQ-033 sw with mem_ready held 0 for 3 cycles in MEMWR -> state=5 for 4 cycles with mem_write=1; then FETCH; reg_write never 1.
REQ-034 bne (000101) -> BRANCH with pc_write_cond=1, bne=1, pc_source=01; beq (000100) -> identical except bne=0.
REQ-035 Opcode 111111 with TRAP_EN=1 -> state=12, exc=1 held for 20 cycles; assert res=0 -> state=0, exc=0. Same opcode with TRAP_EN=0 -> DECODE then FETCH.
REQ-036 FETCH with mem_ready=0 for 2 cycles -> ir_write=0 and pc_write=0 during the stall, each 1 for exactly one cycle when mem_ready=1.
REQ-037 res=0 asserted in MEMRD while mem_ready=0 -> outputs all 0 asynchronously, before the next clk edge.
